// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the decode-stage immediate generator.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_C    = 3'd6
    } imm_fmt_e;

    // Occupancy of the main/skid buffer pair.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Instruction-in / immediate-out stream bundle for imm_gen_stage.
// Handshake: a beat moves on a rising edge where valid && ready; the sender keeps
// its payload stable while valid is high and ready is low, and ready never depends on valid.
interface imm_gen_stage_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           instr;
    logic                  immgen_en;
    logic [TAG_W-1:0]      tag_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       imm_out;
    imm_pkg::imm_fmt_e     imm_fmt;
    logic [TAG_W-1:0]      tag_out;

    modport slave (
        input  in_valid, instr, immgen_en, tag_in, out_ready,
        output in_ready, out_valid, imm_out, imm_fmt, tag_out
    );

    modport master (
        output in_valid, instr, immgen_en, tag_in, out_ready,
        input  in_ready, out_valid, imm_out, imm_fmt, tag_out
    );
endinterface

// File: rtl/imm_decode_comb.sv
// Combinational immediate decoder: RV32I/RV64I formats plus an optional RVC subset.
module imm_decode_comb
    import imm_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENABLE_C = 0
) (
    input  logic [31:0]     instr,
    input  logic            en,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt
);

    // Every format fits in 32 bits; the final step sign-extends bit 31 to XLEN.
    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        fmt   = IMM_NONE;
        if (en) begin
            if ((ENABLE_C != 0) && (instr[1:0] != 2'b11)) begin
                case ({instr[1:0], instr[15:13]})
                    5'b01_000, 5'b01_010: begin
                        fmt   = IMM_C;
                        imm32 = {{26{instr[12]}}, instr[12], instr[6:2]};
                    end
                    5'b01_011: begin
                        // c.lui with rd 0 or 2 is reserved / c.addi16sp, not decoded here
                        if ((instr[11:7] != 5'd0) && (instr[11:7] != 5'd2)) begin
                            fmt   = IMM_C;
                            imm32 = {{14{instr[12]}}, instr[12], instr[6:2], 12'b0};
                        end
                    end
                    5'b00_010, 5'b00_110: begin
                        fmt   = IMM_C;
                        imm32 = {25'b0, instr[5], instr[12:10], instr[6], 2'b0};
                    end
                    5'b01_101: begin
                        fmt   = IMM_C;
                        imm32 = {{20{instr[12]}}, instr[12], instr[8], instr[10:9], instr[6],
                                 instr[7], instr[2], instr[11], instr[5:3], 1'b0};
                    end
                    5'b01_110, 5'b01_111: begin
                        fmt   = IMM_C;
                        imm32 = {{23{instr[12]}}, instr[12], instr[6:5], instr[2],
                                 instr[11:10], instr[4:3], 1'b0};
                    end
                    default: ;
                endcase
            end else begin
                case (instr[6:0])
                    OP_IMM, LOAD, JALR: begin
                        fmt   = IMM_I;
                        imm32 = {{20{instr[31]}}, instr[31:20]};
                    end
                    OP_IMM_32: begin
                        if (XLEN == 64) begin
                            fmt   = IMM_I;
                            imm32 = {{20{instr[31]}}, instr[31:20]};
                        end
                    end
                    STORE: begin
                        fmt   = IMM_S;
                        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                    end
                    BRANCH: begin
                        fmt   = IMM_B;
                        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                 instr[11:8], 1'b0};
                    end
                    LUI, AUIPC: begin
                        fmt   = IMM_U;
                        imm32 = {instr[31:12], 12'b0};
                    end
                    JAL: begin
                        fmt   = IMM_J;
                        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                 instr[30:21], 1'b0};
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        imm       = {XLEN{imm32[31]}};
        imm[31:0] = imm32;
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator stage: decoder feeding a main+skid buffer so in_ready is a flop.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENABLE_C = 0,
    parameter int TAG_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    imm_gen_stage_if.slave      bus,
    output buf_state_e          state
);

    buf_state_e       state_next;
    logic             in_ready_q;
    logic             accept;
    logic             pop;
    logic             load_main;
    logic             load_skid;
    logic             move_skid;

    logic [XLEN-1:0]  dec_imm;
    imm_fmt_e         dec_fmt;

    logic [XLEN-1:0]  main_imm, skid_imm;
    imm_fmt_e         main_fmt, skid_fmt;
    logic [TAG_W-1:0] main_tag, skid_tag;

    imm_decode_comb #(.XLEN(XLEN), .ENABLE_C(ENABLE_C)) u_decode (
        .instr (bus.instr),
        .en    (bus.immgen_en),
        .imm   (dec_imm),
        .fmt   (dec_fmt)
    );

    assign accept        = bus.in_valid && in_ready_q;
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state != BUF_EMPTY);
    assign bus.imm_out   = main_imm;
    assign bus.imm_fmt   = main_fmt;
    assign bus.tag_out   = main_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BUF_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_next;
            in_ready_q <= (state_next != BUF_TWO);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BUF_EMPTY: if (accept) state_next = BUF_ONE;
            BUF_ONE: begin
                if (accept && !pop)      state_next = BUF_TWO;
                else if (pop && !accept) state_next = BUF_EMPTY;
            end
            BUF_TWO:   if (pop) state_next = BUF_ONE;
            default:   state_next = BUF_EMPTY;
        endcase
        if (flush) state_next = BUF_EMPTY;
    end

    // Datapath load controls; a flush cycle loads nothing so the dropped beat never lands.
    always_comb begin
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (!flush) begin
            case (state)
                BUF_EMPTY: load_main = accept;
                BUF_ONE: begin
                    load_main = accept && pop;
                    load_skid = accept && !pop;
                end
                BUF_TWO:   move_skid = pop;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_imm <= '0;
            main_fmt <= IMM_NONE;
            main_tag <= '0;
            skid_imm <= '0;
            skid_fmt <= IMM_NONE;
            skid_tag <= '0;
        end else begin
            if (load_main) begin
                main_imm <= dec_imm;
                main_fmt <= dec_fmt;
                main_tag <= bus.tag_in;
            end else if (move_skid) begin
                main_imm <= skid_imm;
                main_fmt <= skid_fmt;
                main_tag <= skid_tag;
            end
            if (load_skid) begin
                skid_imm <= dec_imm;
                skid_fmt <= dec_fmt;
                skid_tag <= bus.tag_in;
            end
        end
    end

endmodule
